// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } uart_state_e;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_FRAME_BYTES    = 3;
  localparam int CLKS_PER_BIT_115200 = 1302;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap.
// While clear is high the counter is held at zero and no tick is produced, so
// the first tick after clear drops arrives exactly CLKS_PER_BIT cycles later.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1302
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == LAST);
  assign tick   = w_wrap && !clear;

  // Free-running bit-period counter, restarted by clear and on every wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame16.sv
// 16-bit word transmitter: sends MSB byte, LSB byte and a trailer byte as 8N1
// characters, with GAP_BITS idle bit times between bytes. tx_out is driven
// straight from a register so the line never glitches.
module uart_tx_frame16
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int          GAP_BITS     = 1,
  parameter logic [7:0]  TRAILER      = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_i,
  output logic        tx_out,
  output logic        busy,
  output logic        done
);

  localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(UART_FRAME_BYTES - 1);

  uart_state_e   r_state, w_state_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [1:0]    r_byte_idx, w_byte_idx_next;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_next;
  logic [15:0]   r_word, w_word_next;
  logic          r_tx, w_tx_next;
  logic          r_done, w_done_next;

  logic          w_tick;
  logic          w_baud_clear;
  logic [7:0]    w_cur_byte;
  logic [2:0]    w_bit_inc;

  // The baud counter sits at zero while idle so the start bit gets a full period.
  assign w_baud_clear = (r_state == IDLE);
  assign w_bit_inc    = r_bit_idx + 3'd1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (w_baud_clear),
    .tick  (w_tick)
  );

  // Select the byte currently on the wire: MSB, LSB, then trailer.
  always_comb begin
    w_cur_byte = TRAILER;
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_word[15:8];
      2'd1:    w_cur_byte = r_word[7:0];
      default: w_cur_byte = TRAILER;
    endcase
  end

  // Next-state logic; tx level is computed for the next state so it can be registered.
  always_comb begin
    w_state_next    = r_state;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    w_gap_cnt_next  = r_gap_cnt;
    w_word_next     = r_word;
    w_tx_next       = r_tx;
    w_done_next     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (start) begin
          w_word_next     = data_i;
          w_byte_idx_next = 2'd0;
          w_bit_idx_next  = 3'd0;
          w_state_next    = START;
          w_tx_next       = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = 3'd0;
          w_tx_next      = w_cur_byte[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == BIT_LAST) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = w_bit_inc;
            w_tx_next      = w_cur_byte[w_bit_inc];
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_byte_idx == BYTE_LAST) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
            w_tx_next    = 1'b1;
          end else begin
            w_byte_idx_next = r_byte_idx + 2'd1;
            if (GAP_BITS > 0) begin
              w_state_next   = GAP;
              w_gap_cnt_next = '0;
              w_tx_next      = 1'b1;
            end else begin
              w_state_next = START;
              w_tx_next    = 1'b0;
            end
          end
        end
      end
      GAP: begin
        if (w_tick) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_next = START;
            w_tx_next    = 1'b0;
          end else begin
            w_gap_cnt_next = r_gap_cnt + GW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_gap_cnt  <= '0;
      r_word     <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_idx  <= w_bit_idx_next;
      r_byte_idx <= w_byte_idx_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_word     <= w_word_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
    end
  end

  assign tx_out = r_tx;
  assign done   = r_done;
  assign busy   = (r_state != IDLE);

endmodule
